// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the mux round-robin arbiter.
// State encoding and requester count.
package mux_rr_arbiter_pkg;

  localparam int NREQ = 4;
  localparam logic [1:0] LAST_RST = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_rr_arbiter_mux4_1.sv
// Four-input, four-bit combinational mux.
// Datapath shared by the arbiter's requesters.
module mux4_1 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = a;
    unique case (sel)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded hold time over a shared mux4_1.
// Grant, select and the registered output word are all flops.
import mux_rr_arbiter_pkg::*;

module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [3:0] out,
  output logic       out_valid
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last;
  logic [3:0]       mux_y;

  // First set bit scanning from+1, from+2, ...; from itself is last.
  function automatic logic [1:0] next_idx(
    input logic [3:0] r,
    input logic [1:0] from
  );
    logic [1:0] idx;
    next_idx = from;
    for (int k = NREQ; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) next_idx = idx;
    end
  endfunction

  mux4_1 u_mux (
    .a   (A),
    .b   (B),
    .c   (C),
    .d   (D),
    .sel (sel),
    .y   (mux_y)
  );

  logic [1:0] win_idle;
  logic [1:0] win_rot;
  logic       drop;
  logic       expire;
  logic       others;
  logic       rot;
  logic       stay;

  always_comb begin
    win_idle = next_idx(req, last);
    win_rot  = next_idx(req, sel);
    drop     = ~req[sel];
    expire   = (cnt == CNT_W'(MAX_HOLD));
    others   = |(req & ~(4'b0001 << sel));
    rot      = ~drop & expire & others;
    stay     = ~drop & expire & ~others;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= 4'b0000;
      sel       <= 2'b00;
      cnt       <= '0;
      last      <= LAST_RST;
      out       <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      out       <= mux_y;
      out_valid <= (state == S_GRANT);
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_GRANT;
            gnt   <= 4'b0001 << win_idle;
            sel   <= win_idle;
            cnt   <= CNT_W'(1);
          end
        end
        S_GRANT: begin
          unique case (1'b1)
            drop: begin
              last <= sel;
              if (|req) begin
                gnt <= 4'b0001 << win_rot;
                sel <= win_rot;
                cnt <= CNT_W'(1);
              end else begin
                state <= S_IDLE;
                gnt   <= 4'b0000;
              end
            end
            rot: begin
              last <= sel;
              gnt  <= 4'b0001 << win_rot;
              sel  <= win_rot;
              cnt  <= CNT_W'(1);
            end
            stay: begin
              cnt <= CNT_W'(1);
            end
            default: begin
              cnt <= cnt + CNT_W'(1);
            end
          endcase
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter.
// Reference model tracks holder index, hold count and rotation pointer.
module tb_mux_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] A = 4'd4, B = 4'd5, C = 4'd8, D = 4'd15;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] out;
  logic       out_valid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  int         m_hold;
  int         m_cnt;
  int         m_last;
  int         m_sel;
  logic [3:0] m_out;
  logic       m_valid;

  function automatic logic [3:0] dat(input int i);
    case (i)
      0: dat = A;
      1: dat = B;
      2: dat = C;
      default: dat = D;
    endcase
  endfunction

  function automatic int winner(input logic [3:0] r, input int from);
    winner = -1;
    for (int k = 4; k >= 1; k--)
      if (r[(from + k) % 4]) winner = (from + k) % 4;
  endfunction

  task automatic model_reset();
    m_hold  = -1;
    m_cnt   = 0;
    m_last  = 3;
    m_sel   = 0;
    m_out   = 4'd0;
    m_valid = 1'b0;
  endtask

  task automatic model_update();
    int w;
    m_out   = dat(m_sel);
    m_valid = (m_hold >= 0);
    if (m_hold < 0) begin
      w = winner(req, m_last);
      if (w >= 0) begin
        m_hold = w; m_sel = w; m_cnt = 1;
      end
    end else if (!req[m_hold]) begin
      m_last = m_hold;
      w = winner(req, m_hold);
      if (w >= 0) begin
        m_hold = w; m_sel = w; m_cnt = 1;
      end else begin
        m_hold = -1;
      end
    end else if (m_cnt == MAXH) begin
      if ((req & ~(4'b0001 << m_hold)) != 4'b0000) begin
        m_last = m_hold;
        w = winner(req, m_hold);
        m_hold = w; m_sel = w;
      end
      m_cnt = 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_model();
    check("gnt", 32'(gnt), (m_hold >= 0) ? 32'(1) << m_hold : 32'd0);
    check("sel", 32'(sel), 32'(m_sel));
    check("out", 32'(out), 32'(m_out));
    check("out_valid", 32'(out_valid), 32'(m_valid));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  // Called just after a negedge; leaves rst_n released at a later negedge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // single requester 0
    req = 4'b0001;
    step();
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_sel", 32'(sel), 32'd0);
    check("t1_valid_lag", 32'(out_valid), 32'd0);
    step();
    check("t1_out", 32'(out), 32'd4);
    check("t1_valid", 32'(out_valid), 32'd1);

    // all four, rotation every MAX_HOLD cycles
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      step();
      check("t2_gnt", 32'(gnt), 32'(1) << (i / 4));
      if (i >= 1) check("t2_out", 32'(out), 32'(dat((i - 1) / 4)));
    end

    // lone requester keeps grant across count wrap
    pulse_reset();
    req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_gnt", 32'(gnt), 32'b0100);
      if (i >= 1) check("t3_out", 32'(out), 32'd8);
    end

    // holder drops, grant moves with no bubble
    req = 4'b0010;
    step();
    check("t4_gnt1", 32'(gnt), 32'b0010);
    req = 4'b1000;
    step();
    check("t4_gnt3", 32'(gnt), 32'b1000);
    check("t4_sel3", 32'(sel), 32'd3);
    step();
    check("t4_out", 32'(out), 32'd15);

    // all drop
    req = 4'b0000;
    step();
    check("t5_gnt", 32'(gnt), 32'd0);
    step();
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_hold", 32'(out), 32'd15);

    // reset mid-grant
    req = 4'b1111;
    repeat (6) step();
    pulse_reset();
    step();
    check("t6_gnt", 32'(gnt), 32'b0001);

    // random phase with held request patterns and rare resets
    for (int i = 0; i < 120; i++) begin
      req = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 9)) step();
      if ($urandom_range(0, 40) == 0) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
